// File: rtl/data_memory_ml.sv
// Data memory for the MEM stage with a fixed multi-cycle access latency.
// Byte/half/word loads and stores, sign/zero-extended loads, misalignment flagging.
module data_memory_ml #(
  parameter int unsigned WORD_LEN    = 32,
  parameter int unsigned ADDRESS_LEN = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] adr,
  input  logic [WORD_LEN-1:0]    write_data,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [1:0]             size,
  input  logic                   sign_ext,
  output logic [WORD_LEN-1:0]    out,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned CntW     = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam int unsigned NumLanes = WORD_LEN / 8;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q;
  logic                req, accept, finish;

  // Request latched at accept; inputs are ignored afterwards.
  logic [IdxW+1:0]     adr_q;
  logic [WORD_LEN-1:0] wdata_q;
  logic [1:0]          size_q;
  logic                sext_q;
  logic                write_q;

  logic [IdxW+1:0]     acc_adr;
  logic [WORD_LEN-1:0] acc_wdata;
  logic [1:0]          acc_size;
  logic                acc_sext;
  logic                acc_write;
  logic [IdxW-1:0]     acc_idx;
  logic [1:0]          acc_lane;

  logic                misaligned;
  logic [NumLanes-1:0] be;
  logic [WORD_LEN-1:0] wr_lanes;
  logic [WORD_LEN-1:0] rd_word;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [WORD_LEN-1:0] load_val;
  logic                mem_we;

  logic [WORD_LEN-1:0] mem [DEPTH];

  assign req = mem_read | mem_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          busy   = 1'b1;
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_d = StDone;
            finish  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 2);
          end
        end
      end
      StWait: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
          finish  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY==1 the access happens on the accept edge, so use the live inputs there.
  always_comb begin
    if (state_q == StIdle) begin
      acc_adr   = adr[IdxW+1:0];
      acc_wdata = write_data;
      acc_size  = size;
      acc_sext  = sign_ext;
      acc_write = mem_write;
    end else begin
      acc_adr   = adr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_sext  = sext_q;
      acc_write = write_q;
    end
  end

  assign acc_idx  = acc_adr[IdxW+1:2];
  assign acc_lane = acc_adr[1:0];

  always_comb begin
    misaligned = 1'b1;
    unique case (acc_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = acc_lane[0];
      2'b10:   misaligned = |acc_lane;
      default: misaligned = 1'b1;
    endcase
  end

  // Replicate store data across lanes; byte enables select which lanes land.
  always_comb begin
    be       = '0;
    wr_lanes = acc_wdata;
    unique case (acc_size)
      2'b00: begin
        be[acc_lane] = 1'b1;
        wr_lanes     = {NumLanes{acc_wdata[7:0]}};
      end
      2'b01: begin
        be       = acc_lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{acc_wdata[15:0]}};
      end
      2'b10:   be = '1;
      default: be = '0;
    endcase
  end

  assign rd_word = mem[acc_idx];
  assign rd_byte = rd_word[{acc_lane, 3'b000} +: 8];
  assign rd_half = acc_lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_val = rd_word;
    unique case (acc_size)
      2'b00:   load_val = {{(WORD_LEN-8){acc_sext & rd_byte[7]}}, rd_byte};
      2'b01:   load_val = {{(WORD_LEN-16){acc_sext & rd_half[15]}}, rd_half};
      default: load_val = rd_word;
    endcase
  end

  assign mem_we = finish & acc_write & ~misaligned & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= finish & misaligned;
      if (finish) begin
        out <= (acc_write | misaligned) ? '0 : load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      adr_q   <= adr[IdxW+1:0];
      wdata_q <= write_data;
      size_q  <= size;
      sext_q  <= sign_ext;
      write_q <= mem_write;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NumLanes; k++) begin
        if (be[k]) begin
          mem[acc_idx][8*k +: 8] <= wr_lanes[8*k +: 8];
        end
      end
    end
  end

  assign done = (state_q == StDone);
  assign err  = err_q;

  // Upper address bits wrap the word index modulo DEPTH.
  if (ADDRESS_LEN > IdxW + 2) begin : g_unused_adr
    logic unused_adr_hi;
    assign unused_adr_hi = ^adr[ADDRESS_LEN-1:IdxW+2];
  end

endmodule

// File: tb/tb_data_memory_ml.sv
// Bench for data_memory_ml: two configurations (LATENCY=2/DEPTH=1024, LATENCY=1/DEPTH=16)
// checked every cycle against a cycle-count reference model, plus literal expectations.
module tb_data_memory_ml;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic [31:0] adr        [2];
  logic [31:0] write_data [2];
  logic        mem_read   [2];
  logic        mem_write  [2];
  logic [1:0]  size       [2];
  logic        sign_ext   [2];
  logic [31:0] out_w      [2];
  logic        busy_w     [2];
  logic        done_w     [2];
  logic        err_w      [2];

  int vectors;
  int miscompares;
  bit check_en;

  always #5 clk = ~clk;

  data_memory_ml #(
    .WORD_LEN(32), .ADDRESS_LEN(32), .DEPTH(1024), .LATENCY(2)
  ) u_dut0 (
    .clk(clk), .rst(rst[0]), .adr(adr[0]), .write_data(write_data[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .size(size[0]),
    .sign_ext(sign_ext[0]), .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .err(err_w[0])
  );

  data_memory_ml #(
    .WORD_LEN(32), .ADDRESS_LEN(32), .DEPTH(16), .LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]), .adr(adr[1]), .write_data(write_data[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .size(size[1]),
    .sign_ext(sign_ext[1]), .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .err(err_w[1])
  );

  // Reference model: an access accepted in cycle t completes in cycle t+LAT.
  int          cyc = 0;
  int          acc_cyc [2];
  logic [31:0] p_adr   [2];
  logic [31:0] p_wd    [2];
  logic [1:0]  p_size  [2];
  bit          p_sx    [2];
  bit          p_wr    [2];
  bit          res_err [2];
  logic [31:0] out_m   [2];
  logic [31:0] mem_m   [2][1024];

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int dep_of(input int i);
    return (i == 0) ? 1024 : 16;
  endfunction

  function automatic bit is_free(input int i);
    return (acc_cyc[i] < 0) || (cyc > acc_cyc[i] + lat_of(i));
  endfunction

  function automatic bit exp_done(input int i);
    return (acc_cyc[i] >= 0) && (cyc == acc_cyc[i] + lat_of(i));
  endfunction

  function automatic bit exp_busy(input int i);
    return ((acc_cyc[i] >= 0) && (cyc < acc_cyc[i] + lat_of(i))) ||
           (is_free(i) && (mem_read[i] || mem_write[i]));
  endfunction

  task automatic perform(input int i);
    logic [31:0] a;
    logic [31:0] w;
    logic [63:0] field;
    logic [63:0] mask;
    logic [63:0] v;
    int          lane;
    int          nb;
    int          widx;
    bit          bad;
    a    = p_adr[i];
    lane = int'(a[1:0]);
    nb   = 1 << p_size[i];
    widx = int'((a >> 2) % dep_of(i));
    bad  = (p_size[i] == 2'd3) || (p_size[i] == 2'd1 && a[0]) || (p_size[i] == 2'd2 && lane != 0);
    res_err[i] = bad;
    if (bad) begin
      out_m[i] = 32'h0;
    end else begin
      field = (64'd1 << (8 * nb)) - 64'd1;
      mask  = field << (8 * lane);
      w     = mem_m[i][widx];
      if (p_wr[i]) begin
        v = ({32'h0, w} & ~mask) | (({32'h0, p_wd[i]} << (8 * lane)) & mask);
        mem_m[i][widx] = v[31:0];
        out_m[i] = 32'h0;
      end else begin
        v = ({32'h0, w} >> (8 * lane)) & field;
        if (p_sx[i] && nb < 4 && v[8*nb-1]) v = v | ~field;
        out_m[i] = v[31:0];
      end
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        acc_cyc[i] = -1;
        out_m[i]   = 32'h0;
      end else begin
        if (is_free(i) && (mem_read[i] || mem_write[i])) begin
          acc_cyc[i] = cyc;
          p_adr[i]   = adr[i];
          p_wd[i]    = write_data[i];
          p_size[i]  = size[i];
          p_sx[i]    = sign_ext[i];
          p_wr[i]    = mem_write[i];
        end
        if (acc_cyc[i] >= 0 && cyc + 1 == acc_cyc[i] + lat_of(i)) perform(i);
      end
    end
    cyc++;
  end

  task automatic chk(input string name, input int i, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cycle %0d: got %h expected %h", name, i, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 32'(busy_w[i]), 32'(exp_busy(i)));
        chk("done", i, 32'(done_w[i]), 32'(exp_done(i)));
        chk("err",  i, 32'(err_w[i]),  32'(exp_done(i) && res_err[i]));
        chk("out",  i, out_w[i], out_m[i]);
      end
    end
  end

  // One request, then scramble the inputs while it is in flight; returns at done's negedge.
  task automatic op(input int i, input bit rd, input bit wr, input logic [31:0] a,
                    input logic [31:0] wd, input logic [1:0] s, input bit sx, output int lat);
    @(posedge clk); #1;
    mem_read[i]   = rd;
    mem_write[i]  = wr;
    adr[i]        = a;
    write_data[i] = wd;
    size[i]       = s;
    sign_ext[i]   = sx;
    @(posedge clk); #1;
    mem_read[i]   = 1'b0;
    mem_write[i]  = 1'b0;
    adr[i]        = $urandom;
    write_data[i] = $urandom;
    size[i]       = 2'($urandom % 4);
    sign_ext[i]   = 1'($urandom % 2);
    lat = 1;
    @(negedge clk);
    while (done_w[i] !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (done_w[i] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout inst%0d: got no done after %0d cycles expected done", i, lat);
    end
  endtask

  initial begin
    int lat;
    vectors     = 0;
    miscompares = 0;
    check_en    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; mem_read[i] = 1'b0; mem_write[i] = 1'b0; adr[i] = 32'h0;
      write_data[i] = 32'h0; size[i] = 2'b10; sign_ext[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out",  i, out_w[i], 32'h0);
      chk("rst_busy", i, 32'(busy_w[i]), 32'h0);
      chk("rst_done", i, 32'(done_w[i]), 32'h0);
      chk("rst_err",  i, 32'(err_w[i]), 32'h0);
    end

    // LATENCY=2 directed sequence
    op(0, 0, 1, 32'h40, 32'hDEADBEEF, 2'b10, 0, lat);
    chk("sw_lat", 0, lat, 2);
    chk("sw_err", 0, 32'(err_w[0]), 32'h0);
    op(0, 1, 0, 32'h40, 32'h0, 2'b10, 0, lat);
    chk("lw_lat", 0, lat, 2);
    chk("lw40", 0, out_w[0], 32'hDEADBEEF);
    op(0, 0, 1, 32'h41, 32'hABCDEF7F, 2'b00, 0, lat);
    chk("sb_out", 0, out_w[0], 32'h0);
    op(0, 1, 0, 32'h40, 32'h0, 2'b10, 0, lat);
    chk("lw_after_sb", 0, out_w[0], 32'hDEAD7FEF);
    op(0, 1, 0, 32'h43, 32'h0, 2'b00, 1, lat);
    chk("lb43", 0, out_w[0], 32'hFFFFFFDE);
    op(0, 1, 0, 32'h43, 32'h0, 2'b00, 0, lat);
    chk("lbu43", 0, out_w[0], 32'h000000DE);
    op(0, 0, 1, 32'h42, 32'h55558001, 2'b01, 0, lat);
    op(0, 1, 0, 32'h42, 32'h0, 2'b01, 1, lat);
    chk("lh42", 0, out_w[0], 32'hFFFF8001);
    op(0, 1, 0, 32'h42, 32'h0, 2'b01, 0, lat);
    chk("lhu42", 0, out_w[0], 32'h00008001);
    op(0, 1, 0, 32'h40, 32'h0, 2'b10, 0, lat);
    chk("lw_after_sh", 0, out_w[0], 32'h80017FEF);
    op(0, 1, 0, 32'h42, 32'h0, 2'b10, 0, lat);
    chk("lw42_err", 0, 32'(err_w[0]), 32'h1);
    chk("lw42_out", 0, out_w[0], 32'h0);
    op(0, 1, 0, 32'h41, 32'h0, 2'b01, 1, lat);
    chk("lh41_err", 0, 32'(err_w[0]), 32'h1);
    op(0, 0, 1, 32'h40, 32'h0, 2'b11, 0, lat);
    chk("sz11_err", 0, 32'(err_w[0]), 32'h1);
    op(0, 1, 0, 32'h40, 32'h0, 2'b10, 0, lat);
    chk("lw_unchanged", 0, out_w[0], 32'h80017FEF);

    // Reset while a store is in WAIT
    @(posedge clk); #1;
    mem_write[0] = 1'b1; adr[0] = 32'h40; write_data[0] = 32'h12345678; size[0] = 2'b10;
    @(posedge clk); #1;
    mem_write[0] = 1'b0; rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy", 0, 32'(busy_w[0]), 32'h0);
    chk("abort_done", 0, 32'(done_w[0]), 32'h0);
    chk("abort_out",  0, out_w[0], 32'h0);
    op(0, 1, 0, 32'h40, 32'h0, 2'b10, 0, lat);
    chk("lw_after_abort", 0, out_w[0], 32'h80017FEF);

    // LATENCY=1, DEPTH=16
    op(1, 0, 1, 32'h40, 32'h5, 2'b10, 0, lat);
    chk("l1_sw_lat", 1, lat, 1);
    op(1, 1, 0, 32'h0, 32'h0, 2'b10, 0, lat);
    chk("l1_lw0", 1, out_w[1], 32'h5);
    op(1, 1, 0, 32'hFFFFFF00, 32'h0, 2'b10, 0, lat);
    chk("l1_wrap", 1, out_w[1], 32'h5);
    op(1, 1, 1, 32'h4, 32'h77, 2'b10, 0, lat);
    chk("l1_rw_out", 1, out_w[1], 32'h0);
    op(1, 1, 0, 32'h4, 32'h0, 2'b10, 0, lat);
    chk("l1_rw_store", 1, out_w[1], 32'h77);

    // Fill the random-phase windows so every load reads defined data
    for (int k = 0; k < 16; k++) begin
      op(0, 0, 1, 32'((16 + k) << 2), $urandom, 2'b10, 0, lat);
      op(1, 0, 1, 32'(k << 2), $urandom, 2'b10, 0, lat);
    end

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        int  kind;
        int  k;
        int  low;
        bit  req;
        kind = int'($urandom % 4);
        req  = ($urandom % 3) != 0;
        mem_read[i]  = req && (kind != 1);
        mem_write[i] = req && (kind == 1 || kind == 2);
        size[i]      = (($urandom % 8) == 0) ? 2'b11 : 2'($urandom % 3);
        k   = int'($urandom % 16);
        low = int'($urandom % 4);
        if (($urandom % 4) != 0) begin
          if (size[i] == 2'b01) low = low & 2;
          if (size[i] == 2'b10) low = 0;
        end
        if (i == 0) adr[i] = ($urandom & 32'hFFFFF000) | 32'((16 + k) << 2) | 32'(low);
        else        adr[i] = ($urandom & 32'hFFFFFFC0) | 32'(k << 2) | 32'(low);
        write_data[i] = $urandom;
        sign_ext[i]   = 1'($urandom % 2);
        rst[i]        = (($urandom % 128) == 0);
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; rst[i] = 1'b0;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
